// File: rtl/instr_decoder.sv
// Two-byte SPI frame decoder: command byte (rw, lane, address) then data byte,
// producing single-cycle register-file read/write strobes and read-back data.
module instr_decoder #(
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cs_n,
  input  logic              byte_sync,
  input  logic [7:0]        data_in,
  output logic [7:0]        data_out,
  output logic              read,
  output logic              write,
  output logic [ADDR_W-1:0] addr,
  output logic              hi_sel,
  input  logic [7:0]        data_read,
  output logic [7:0]        data_write
);

  typedef enum logic [2:0] {
    S_CMD   = 3'd0,
    S_RD    = 3'd1,
    S_RDLAT = 3'd2,
    S_DATA  = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t state_reg;
  logic   sync_q;
  logic   byte_event;

  // byte_sync is a level that may last several cycles; act only on its rising edge
  assign byte_event = byte_sync & ~sync_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg  <= S_CMD;
      sync_q     <= 1'b0;
      data_out   <= 8'h00;
      read       <= 1'b0;
      write      <= 1'b0;
      addr       <= '0;
      hi_sel     <= 1'b0;
      data_write <= 8'h00;
    end else begin
      sync_q <= byte_sync;
      read   <= 1'b0;
      write  <= 1'b0;
      if (cs_n) begin
        // chip select high aborts the frame; an event in the same cycle is dropped
        state_reg <= S_CMD;
        data_out  <= 8'h00;
      end else begin
        case (state_reg)
          S_CMD: begin
            if (byte_event) begin
              addr   <= data_in[ADDR_W-1:0];
              hi_sel <= data_in[6];
              if (data_in[7]) begin
                state_reg <= S_DATA;
              end else begin
                read      <= 1'b1;
                state_reg <= S_RD;
              end
            end
          end
          S_RD: begin
            state_reg <= S_RDLAT;
          end
          S_RDLAT: begin
            // register file answers one cycle after the read strobe
            data_out  <= data_read;
            state_reg <= S_DONE;
          end
          S_DATA: begin
            if (byte_event) begin
              data_write <= data_in;
              write      <= 1'b1;
              state_reg  <= S_DONE;
            end
          end
          S_DONE: begin
            state_reg <= S_DONE;
          end
          default: begin
            state_reg <= S_CMD;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_instr_decoder.sv
// Directed bench for instr_decoder: a table of whole frames plus hand-written
// sequences for latency, long byte_sync, abort and mid-frame reset.
module tb_instr_decoder;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cs_n = 1'b1;
  logic       byte_sync = 1'b0;
  logic [7:0] data_in = 8'h00;
  logic [7:0] data_out;
  logic       read;
  logic       write;
  logic [5:0] addr;
  logic       hi_sel;
  logic [7:0] data_read = 8'h00;
  logic [7:0] data_write;

  instr_decoder #(.ADDR_W(6)) dut (
    .clk        (clk),
    .rst        (rst),
    .cs_n       (cs_n),
    .byte_sync  (byte_sync),
    .data_in    (data_in),
    .data_out   (data_out),
    .read       (read),
    .write      (write),
    .addr       (addr),
    .hi_sel     (hi_sel),
    .data_read  (data_read),
    .data_write (data_write)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] cmd;
    logic [7:0] dat;
    logic [7:0] rd_val;
    logic       exp_wr;
    logic [5:0] exp_addr;
    logic       exp_hi;
    logic [7:0] exp_dw;
    logic [7:0] exp_dout;
  } vec_t;

  vec_t vecs [6];

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;
  int rd_cnt = 0;
  int wr_cnt = 0;
  logic [5:0] rd_addr, wr_addr;
  logic       rd_hi, wr_hi;
  logic [7:0] wr_dw;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // advance one clock and sample outputs 1 time unit after the edge
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (read) begin
      rd_cnt++;
      rd_addr = addr;
      rd_hi   = hi_sel;
    end
    if (write) begin
      wr_cnt++;
      wr_addr = addr;
      wr_hi   = hi_sel;
      wr_dw   = data_write;
    end
    chk("rd_wr_exclusive", {31'd0, read & write}, 32'd0);
  endtask

  task automatic send_byte(input logic [7:0] b, input int hold);
    data_in   = b;
    byte_sync = 1'b1;
    repeat (hold) tick();
    byte_sync = 1'b0;
    repeat (2) tick();
  endtask

  task automatic run_frame(input int idx, input vec_t v);
    cs_n      = 1'b0;
    data_read = v.rd_val;
    tick();
    rd_cnt = 0;
    wr_cnt = 0;
    send_byte(v.cmd, 2);
    send_byte(v.dat, 3);
    tick();
    chk("frame_rd_cnt", rd_cnt, {31'd0, ~v.exp_wr});
    chk("frame_wr_cnt", wr_cnt, {31'd0, v.exp_wr});
    chk("frame_strobe_addr", {26'd0, (v.exp_wr ? wr_addr : rd_addr)}, {26'd0, v.exp_addr});
    chk("frame_strobe_hi", {31'd0, (v.exp_wr ? wr_hi : rd_hi)}, {31'd0, v.exp_hi});
    chk("frame_data_write", {24'd0, data_write}, {24'd0, v.exp_dw});
    chk("frame_data_out", {24'd0, data_out}, {24'd0, v.exp_dout});
    $display("frame %0d cmd=%02h dat=%02h: rd=%0d wr=%0d addr=%02h hi=%0d dw=%02h dout=%02h",
             idx, v.cmd, v.dat, rd_cnt, wr_cnt, addr, hi_sel, data_write, data_out);
    cs_n = 1'b1;
    tick();
    chk("abort_data_out_clr", {24'd0, data_out}, 32'd0);
    chk("abort_addr_hold", {26'd0, addr}, {26'd0, v.exp_addr});
    tick();
  endtask

  initial begin
    //              cmd    dat    rd_val wr    addr   hi    dw     dout
    vecs[0] = '{8'h85, 8'h3C, 8'h00, 1'b1, 6'h05, 1'b0, 8'h3C, 8'h00};
    vecs[1] = '{8'h4A, 8'h55, 8'hA7, 1'b0, 6'h0A, 1'b1, 8'h3C, 8'hA7};
    vecs[2] = '{8'hFF, 8'h00, 8'h11, 1'b1, 6'h3F, 1'b1, 8'h00, 8'h00};
    vecs[3] = '{8'h3F, 8'h99, 8'h5A, 1'b0, 6'h3F, 1'b0, 8'h00, 8'h5A};
    vecs[4] = '{8'hC1, 8'hE7, 8'h00, 1'b1, 6'h01, 1'b1, 8'hE7, 8'h00};
    vecs[5] = '{8'h00, 8'h12, 8'hFF, 1'b0, 6'h00, 1'b0, 8'hE7, 8'hFF};

    // reset held: byte events must produce nothing
    cs_n    = 1'b0;
    data_in = 8'h85;
    rd_cnt  = 0;
    wr_cnt  = 0;
    for (int i = 0; i < 6; i++) begin
      byte_sync = ~byte_sync;
      tick();
      chk("reset_outputs", {8'd0, read, write, hi_sel, addr, data_out, data_write}, 32'd0);
    end
    byte_sync = 1'b0;
    cs_n      = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    chk("reset_no_strobes", rd_cnt + wr_cnt, 32'd0);
    $display("reset: outputs held at zero, rd=%0d wr=%0d", rd_cnt, wr_cnt);

    for (int i = 0; i < 6; i++) run_frame(i, vecs[i]);

    // read latency: read/addr in cycle after event, data_out two edges after
    cs_n      = 1'b0;
    data_read = 8'hA7;
    tick();
    data_in   = 8'h4A;
    byte_sync = 1'b1;
    tick();
    chk("lat_read_n1", {31'd0, read}, 32'd1);
    chk("lat_addr_n1", {25'd0, hi_sel, addr}, {25'd0, 1'b1, 6'h0A});
    chk("lat_dout_n1", {24'd0, data_out}, 32'd0);
    tick();
    chk("lat_read_n2", {31'd0, read}, 32'd0);
    chk("lat_dout_n2", {24'd0, data_out}, 32'd0);
    byte_sync = 1'b0;
    tick();
    chk("lat_dout_n3", {24'd0, data_out}, 32'hA7);
    $display("read latency: dout=%02h at event+2", data_out);
    cs_n = 1'b1;
    repeat (2) tick();

    // long byte_sync on a write command: single event, no strobe until next byte
    cs_n   = 1'b0;
    tick();
    rd_cnt = 0;
    wr_cnt = 0;
    send_byte(8'h81, 5);
    chk("long_sync_no_strobe", rd_cnt + wr_cnt, 32'd0);
    send_byte(8'h22, 1);
    chk("long_sync_wr_cnt", wr_cnt, 32'd1);
    chk("long_sync_wr", {18'd0, wr_addr, wr_dw}, {18'd0, 6'h01, 8'h22});
    $display("long byte_sync: wr=%0d addr=%02h dw=%02h", wr_cnt, wr_addr, wr_dw);
    cs_n = 1'b1;
    repeat (2) tick();

    // abort between command and data byte, with a byte arriving while deselected
    cs_n   = 1'b0;
    tick();
    rd_cnt = 0;
    wr_cnt = 0;
    send_byte(8'h82, 2);
    cs_n = 1'b1;
    tick();
    send_byte(8'h33, 2);
    chk("abort_no_write", wr_cnt + rd_cnt, 32'd0);
    chk("abort_dw_hold", {24'd0, data_write}, 32'h22);
    cs_n = 1'b0;
    tick();
    send_byte(8'h02, 2);
    chk("abort_new_rd_cnt", rd_cnt, 32'd1);
    chk("abort_new_rd_addr", {26'd0, rd_addr}, 32'h02);
    chk("abort_new_no_wr", wr_cnt, 32'd0);
    $display("abort: rd=%0d wr=%0d addr=%02h", rd_cnt, wr_cnt, rd_addr);
    cs_n = 1'b1;
    repeat (2) tick();

    // cs_n rising in the same cycle as an event: event discarded
    cs_n   = 1'b0;
    tick();
    rd_cnt = 0;
    wr_cnt = 0;
    cs_n      = 1'b1;
    data_in   = 8'h05;
    byte_sync = 1'b1;
    tick();
    cs_n = 1'b0;
    tick();
    byte_sync = 1'b0;
    tick();
    chk("same_cycle_abort", rd_cnt + wr_cnt, 32'd0);
    send_byte(8'h07, 2);
    chk("same_cycle_next_rd", {26'd0, rd_addr}, 32'h07);
    chk("same_cycle_rd_cnt", rd_cnt, 32'd1);
    $display("same-cycle abort: rd=%0d addr=%02h", rd_cnt, rd_addr);
    cs_n = 1'b1;
    repeat (2) tick();

    // reset asserted while in S_RDLAT
    cs_n      = 1'b0;
    data_read = 8'h66;
    tick();
    data_in   = 8'h0B;
    byte_sync = 1'b1;
    tick();
    byte_sync = 1'b0;
    tick();
    rst = 1'b1;
    #1;
    chk("midrst_outputs", {8'd0, read, write, hi_sel, addr, data_out, data_write}, 32'd0);
    repeat (2) tick();
    rst    = 1'b0;
    rd_cnt = 0;
    wr_cnt = 0;
    repeat (2) tick();
    chk("midrst_no_pending", {24'd0, data_out} + rd_cnt + wr_cnt, 32'd0);
    send_byte(8'h90, 2);
    send_byte(8'h11, 2);
    chk("midrst_wr_cnt", wr_cnt, 32'd1);
    chk("midrst_wr", {17'd0, wr_hi, wr_addr, wr_dw}, {17'd0, 1'b0, 6'h10, 8'h11});
    $display("mid-frame reset: wr=%0d addr=%02h dw=%02h", wr_cnt, wr_addr, wr_dw);
    cs_n = 1'b1;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/instr_decoder.md
# instr_decoder

Transaction decoder between the SPI bridge and the peripheral register file. It consumes the byte stream the bridge delivers on `byte_sync`/`data_in` and parses two-byte frames: a command byte followed by a data byte. It turns each frame into one single-cycle register read or write strobe, and returns read data to the bridge on `data_out` for shifting out on MISO.

## Interface
Parameters:
- `ADDR_W`, default 6: register address width; the command byte carries the address in bits [ADDR_W-1:0]; fixed 6 in this design.

Ports (one clock; reset is asynchronous and active-high):
- `clk`  input  1  peripheral clock, shared with the SPI bridge
- `rst`  input  1  asynchronous, active-high reset
- `cs_n`  input  1  SPI chip select, active low; high ends/aborts the frame
- `byte_sync`  input  1  from bridge; level, may stay high several cycles per byte
- `data_in`  input  8  byte from bridge, valid while `byte_sync` high
- `data_out`  output  8  read data to bridge, MSB shifted first
- `read`  output  1  one-cycle read strobe to register file
- `write`  output  1  one-cycle write strobe to register file
- `addr`  output  6  register address
- `hi_sel`  output  1  byte-lane select (command bit 6), forwarded with `addr`
- `data_read`  input  8  register file read data, valid the cycle after `read`
- `data_write`  output  8  write data, valid with `write`

## Operation
- Byte events: `sync_q` registers `byte_sync`; event = `byte_sync & ~sync_q`. Exactly one event per byte regardless of pulse length.
- Command byte: bit7 = 1 write / 0 read; bit6 = `hi_sel`; bits5:0 = `addr`.
- FSM states:
  - S_CMD (reset state): on event, latch `addr`, `hi_sel` and rw from `data_in`. Write goes to S_DATA; read goes to S_RD.
  - S_RD: `read`=1 for this single cycle; then S_RDLAT.
  - S_RDLAT: `data_out` <= `data_read`; then S_DONE.
  - S_DATA: on event, `data_write` <= `data_in`, `write`=1 next cycle; then S_DONE.
  - S_DONE: all further events ignored, `data_out` held, until `cs_n` high.
- `cs_n` high in any state: next cycle S_CMD, `read`=`write`=0, `data_out`=0. `addr`, `hi_sel` and `data_write` hold their values.
- Events are only acted on while `cs_n` low. An event in S_RD or S_RDLAT is ignored.
- `read` and `write` are never high in the same cycle, and each is at most one cycle per frame.

## Timing
- Reset values: `data_out`=0, `read`=0, `write`=0, `addr`=0, `hi_sel`=0, `data_write`=0, `sync_q`=0, state S_CMD.
- All outputs are registered.
- Read path: event detected at edge N. `read` and `addr` are high/valid in cycle N+1. `data_out` is valid from edge N+2, within the bridge's 1-SCLK-bit slack.
- Write path: data event at edge M. `write`=1 and `data_write` valid in cycle M+1. `addr` is stable from the command event through `write`.
- Reset asserted mid-frame: all outputs return to reset values immediately. After reset deasserts, the next event is parsed as a command.
- `cs_n` rising in the same cycle as an event: the abort wins and the event is discarded.

## Test plan
- Reset: hold `rst` high, toggle `byte_sync` -> all outputs 0, no strobes; release -> state S_CMD.
- Write frame: `cs_n`=0, event with `data_in`=0x85, then event with 0x3C -> exactly one `write` pulse, `addr`=0x05, `hi_sel`=0, `data_write`=0x3C, `read` never high.
- Read frame: event 0x4A, `data_read`=0xA7 -> one `read` pulse with `addr`=0x0A, `hi_sel`=1 in the cycle after the event; `data_out`=0xA7 two cycles after the event; a second event -> no strobe.
- Long `byte_sync`: hold `byte_sync` high 5 cycles on the command byte 0x81 -> single event, FSM in S_DATA, no strobe until the next rising edge.
- Abort: write command 0x82, then `cs_n`=1 before the data byte -> no `write`; a new frame with read 0x02 -> `read` pulse with `addr`=0x02.
- Mid-frame reset: assert `rst` while in S_RDLAT -> `data_out`=0 and no pending strobe; after release, event 0x90 then 0x11 -> `write` with `addr`=0x10, `data_write`=0x11.
